regfile_wb_arbiter: RTL

- Shares the single write port of the 32x64b register file among NREQ writeback requesters (ALU, load unit, branch-link).
- Round-robin arbitration with valid/ready handshakes.
- Drives registered wr/reg_id_w/data_in straight into the register file write port.
- Keeps a busy-register scoreboard so decode can detect pending writes to a destination register.

---
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port, with a busy-register scoreboard.
// Default build arbitrates round-robin; define WB_FIXED_PRIO_EN for fixed lowest-index priority.
module regfile_wb_arbiter #(
    parameter int N     = 64,
    parameter int R     = 32,
    parameter int ASIZE = $clog2(R),
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ASIZE-1:0] req_id,
    input  logic [NREQ*N-1:0]     req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  claim_valid,
    input  logic [ASIZE-1:0]      claim_id,
    output logic                  wr,
    output logic [ASIZE-1:0]      reg_id_w,
    output logic [N-1:0]          data_in,
    output logic [R-1:0]          busy_mask,
    output logic                  claim_err
);

    logic [NREQ-1:0]  w_grant;
    logic             w_xfer;
    logic [ASIZE-1:0] w_gnt_id;
    logic [N-1:0]     w_gnt_data;
    logic [R-1:0]     w_busy_next;

`ifdef WB_FIXED_PRIO_EN
    // Scanning from the top down lets the lowest valid index overwrite the rest.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_grant = '0;
                w_grant[k] = 1'b1;
            end
        end
    end
`else
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic [PW-1:0] w_idx;
    int            w_scan;

    // Visit offsets from the far end back to the pointer; the last hit is the nearest valid one.
    always_comb begin
        w_grant    = '0;
        w_ptr_next = r_ptr;
        w_scan     = 0;
        w_idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_scan = int'(r_ptr) + i;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            w_idx = PW'(w_scan);
            if (req_valid[w_idx]) begin
                w_grant        = '0;
                w_grant[w_idx] = 1'b1;
                w_ptr_next     = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    assign req_ready = rst ? w_grant : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_gnt_id   = '0;
        w_gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_gnt_id   = req_id[k*ASIZE +: ASIZE];
                w_gnt_data = req_data[k*N +: N];
            end
        end
    end

    // Claim is applied after the clear so a new producer for the same register stays pending.
    always_comb begin
        w_busy_next = busy_mask;
        if (w_xfer) begin
            w_busy_next[w_gnt_id] = 1'b0;
        end
        if (claim_valid) begin
            w_busy_next[claim_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr        <= 1'b0;
            reg_id_w  <= '0;
            data_in   <= '0;
            // NOTE: busy_mask is status flops, not storage, so it must be reset; RAM arrays are not.
            busy_mask <= '0;
            claim_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            wr        <= w_xfer;
            if (w_xfer) begin
                reg_id_w <= w_gnt_id;
                data_in  <= w_gnt_data;
            end
            busy_mask <= w_busy_next;
            claim_err <= claim_valid & busy_mask[claim_id];
        end
    end

endmodule
